cache_controller: RTL and testbench
===================================

# cache_controller

- Sequencing FSM for the 4-way set-associative write-back cache array.
- Accepts one CPU word access at a time and performs tag lookup and LRU update.
- On a miss, evicts the LRU victim (writing it back if dirty), fetches the line from memory and fills it.
- Sits between the CPU load/store port, the cache array (`cache` module) and the backing-memory port.

## Interface
Parameters:
- ADDR_WIDTH, 16, byte address width
- DATA_WIDTH, 32, word/line data width (one word per line)
- CE_PER_WAY, 64, sets per way
- BYTE_OFFSET, 2, byte-offset bits ignored for indexing
- INDEX_WIDTH, $clog2(CE_PER_WAY), set index width
- TAG_WIDTH, ADDR_WIDTH-INDEX_WIDTH-BYTE_OFFSET, tag width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  byte address
- cpu_wdata  in  DATA_WIDTH  write data
- cpu_ready  out  1  controller can accept a request (IDLE)
- cpu_resp  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  read data, valid with cpu_resp
- mem_req  out  1  memory request
- mem_we  out  1  1 = writeback, 0 = fetch
- mem_addr  out  ADDR_WIDTH  line address, low BYTE_OFFSET bits zero
- mem_wdata  out  DATA_WIDTH  writeback data
- mem_ack  in  1  one-cycle completion from memory
- mem_rdata  in  DATA_WIDTH  fetch data, valid with mem_ack
- index  out  INDEX_WIDTH  set index to array
- tag  out  TAG_WIDTH  lookup/fill tag to array
- data_wen  out  1  array line write
- update_lru  out  1  array LRU touch
- target_way  out  2  way for write/LRU touch
- data_in  out  DATA_WIDTH  line write data
- dirty  out  1  dirty bit written with line
- hit  in  1  array hit
- hit_way  in  2  hitting way
- data_out  in  DATA_WIDTH  hit data
- lru_way  in  2  victim way
- victim_dirty  in  1  victim dirty bit
- victim_tag  in  TAG_WIDTH  victim tag
- victim_data  in  DATA_WIDTH  victim data

## Operation

**Request latching and array addressing**
- Request accepted on a rising edge with cpu_req & cpu_ready.
- On acceptance, latch address, we and wdata.
- index and tag are driven from the latched address for the whole transaction.

**Policy**
- Write-back, write-allocate.

**States:** IDLE, LOOKUP, WRITEBACK, ALLOCATE, FILL, RESPOND.

- **IDLE:** cpu_ready=1. On accept → LOOKUP.
- **LOOKUP** (1 cycle):
  - Read hit: update_lru=1, target_way=hit_way; register cpu_rdata←data_out; → RESPOND.
  - Write hit: data_wen=1, update_lru=1, target_way=hit_way, data_in=wdata, dirty=1; → RESPOND.
  - Miss: latch victim way←lru_way, victim tag and victim data.
    - victim_dirty=1 → WRITEBACK.
    - victim_dirty=0 → ALLOCATE.
- **WRITEBACK:** mem_req=1, mem_we=1, mem_addr={victim_tag, index, 0}, mem_wdata=victim data. On mem_ack → ALLOCATE.
- **ALLOCATE:** mem_req=1, mem_we=0, mem_addr={tag, index, 0}. On mem_ack latch mem_rdata → FILL.
- **FILL** (1 cycle):
  - data_wen=1, update_lru=1, target_way=latched victim way.
  - data_in = write ? wdata : fetched word; dirty = write.
  - cpu_rdata ← fetched word.
  - → RESPOND.
- **RESPOND:** cpu_resp=1 for exactly one cycle; → IDLE.

**Array controls**
- data_wen and update_lru are 0 in all states and branches other than those listed above.
- data_in, dirty and target_way are don't-care when data_wen and update_lru are both 0.

**Memory port**
- mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack is sampled.
- mem_req is deasserted the cycle after mem_ack.
- mem_ack outside WRITEBACK/ALLOCATE is ignored.

## Timing

**Reset values**
- cpu_ready=1 (IDLE).
- All other outputs 0: cpu_resp, cpu_rdata, mem_*, index, tag, data_wen, update_lru, target_way, data_in, dirty.

**Latency** (from the accept edge; N = memory ack latency in cycles)
- Hit: cpu_resp asserted in cycle 2 (IDLE→LOOKUP→RESPOND); no mem_req.
- Clean miss: 3+N cycles.
- Dirty miss: 3+2N cycles.

**Handshake and boundary rules**
- cpu_req while busy is not accepted; the requester holds it.
- Back-to-back: the next request can be accepted in the cycle following RESPOND.
- Reset mid-transaction: returns to IDLE asynchronously and drops mem_req immediately. The memory model must discard an abandoned request. The array is reset by the same rst.

## Configuration
- **CACHE_CTRL_STATS_EN defined:** adds outputs hit_count, miss_count and wb_count (16 bits each, saturating at 0xFFFF, reset to 0).
  - hit_count/miss_count increment on the LOOKUP result.
  - wb_count increments on WRITEBACK mem_ack.
- **Undefined:** these ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Package cache_pkg holds:
  - the state enum;
  - address-split localparams (field positions of BYTE_OFFSET, INDEX_WIDTH, TAG_WIDTH);
  - WAY_SEL_W=2.
- One sub-module, cache_ctrl_stats, holds the saturating counters. It is instantiated only under CACHE_CTRL_STATS_EN.

## Test plan
1. **Cold read miss:** after reset, read 0x0104; memory acks 3 cycles later with 0xDEADBEEF → mem_addr=0x0104, mem_we=0, cpu_rdata=0xDEADBEEF with cpu_resp; no writeback.
2. **Read hit:** re-read 0x0104 → cpu_resp 2 cycles after accept, data 0xDEADBEEF, mem_req stays 0.
3. **Dirty eviction:**
   - Write 0x12345678 to 0x0104 (hit).
   - Read 0x0204, 0x0304, 0x0404 (same set 1).
   - Read 0x0504 → WRITEBACK mem_we=1, mem_addr=0x0104, mem_wdata=0x12345678, then fetch of 0x0504.
4. **Write miss:** write 0xCAFEF00D to 0x0808 → fetch of 0x0808, FILL with data_in=0xCAFEF00D and dirty=1; a subsequent read of 0x0808 hits and returns 0xCAFEF00D.
5. **Reset mid-miss:** assert rst while in ALLOCATE → mem_req falls without a clock edge; cpu_ready=1 after release; re-reading the same address misses again.
6. **Stats** (CACHE_CTRL_STATS_EN): after scenarios 1–2 → hit_count=1, miss_count=1, wb_count=0.

Source files
------------

// File: rtl/cache_pkg.sv
// ============================================================================
//  Module  : cache_pkg
//  Purpose : Shared definitions for the cache controller: sequencing state
//            encoding, default address-split geometry and way-select width.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cache_pkg;

    // Way select width for a 4-way array
    localparam int WAY_SEL_W       = 2;

    // Default address geometry: [TAG | INDEX | BYTE_OFFSET]
    localparam int C_ADDR_WIDTH    = 16;
    localparam int C_DATA_WIDTH    = 32;
    localparam int C_CE_PER_WAY    = 64;
    localparam int C_BYTE_OFFSET   = 2;
    localparam int C_INDEX_WIDTH   = $clog2(C_CE_PER_WAY);
    localparam int C_TAG_WIDTH     = C_ADDR_WIDTH - C_INDEX_WIDTH - C_BYTE_OFFSET;
    localparam int C_INDEX_LSB     = C_BYTE_OFFSET;
    localparam int C_TAG_LSB       = C_BYTE_OFFSET + C_INDEX_WIDTH;

    // Sequencing states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_ALLOCATE  = 3'd3,
        ST_FILL      = 3'd4,
        ST_RESPOND   = 3'd5
    } state_t;

endpackage : cache_pkg

`default_nettype wire

// File: rtl/cache_ctrl_stats.sv
// ============================================================================
//  Module  : cache_ctrl_stats
//  Purpose : Saturating event counters (hits, misses, writebacks) for the
//            cache controller. Only instantiated when CACHE_CTRL_STATS_EN
//            is defined.
//  Ports   : clk, rst (async, active-high)
//            i_hit_evt / i_miss_evt / i_wb_evt : one-cycle event strobes
//            o_hit_count / o_miss_count / o_wb_count : saturating counts
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_ctrl_stats
    import cache_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hit_evt,
    input  logic             i_miss_evt,
    input  logic             i_wb_evt,
    output logic [CNT_W-1:0] o_hit_count,
    output logic [CNT_W-1:0] o_miss_count,
    output logic [CNT_W-1:0] o_wb_count
);

    logic [CNT_W-1:0] r_hit;
    logic [CNT_W-1:0] r_miss;
    logic [CNT_W-1:0] r_wb;

    // Counters stick at all-ones rather than wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit  <= '0;
            r_miss <= '0;
            r_wb   <= '0;
        end else begin
            if (i_hit_evt  && (r_hit  != '1)) r_hit  <= r_hit  + 1'b1;
            if (i_miss_evt && (r_miss != '1)) r_miss <= r_miss + 1'b1;
            if (i_wb_evt   && (r_wb   != '1)) r_wb   <= r_wb   + 1'b1;
        end
    end

    assign o_hit_count  = r_hit;
    assign o_miss_count = r_miss;
    assign o_wb_count   = r_wb;

endmodule : cache_ctrl_stats

`default_nettype wire

// File: rtl/cache_controller.sv
// ============================================================================
//  Module  : cache_controller
//  Purpose : Sequencing FSM for a 4-way set-associative write-back,
//            write-allocate cache array. Handles one CPU word access at a
//            time: lookup + LRU touch on hit; on miss, optional writeback
//            of the dirty LRU victim, line fetch from memory and fill.
//  Ports   : clk, rst (async, active-high)
//            CPU    : cpu_req/we/addr/wdata in; cpu_ready/resp/rdata out
//            Memory : mem_req/we/addr/wdata out; mem_ack/rdata in
//            Array  : index/tag/data_wen/update_lru/target_way/data_in/dirty
//                     out; hit/hit_way/data_out/lru_way/victim_* in
//  Config  : CACHE_CTRL_STATS_EN adds hit_count/miss_count/wb_count outputs
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = C_ADDR_WIDTH,
    parameter int DATA_WIDTH  = C_DATA_WIDTH,
    parameter int CE_PER_WAY  = C_CE_PER_WAY,
    parameter int BYTE_OFFSET = C_BYTE_OFFSET,
    parameter int INDEX_WIDTH = $clog2(CE_PER_WAY),
    parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - BYTE_OFFSET
) (
    input  logic                  clk,
    input  logic                  rst,
    // CPU port
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_resp,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    // Backing-memory port
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    // Cache array port
    output logic [INDEX_WIDTH-1:0] index,
    output logic [TAG_WIDTH-1:0]   tag,
    output logic                   data_wen,
    output logic                   update_lru,
    output logic [WAY_SEL_W-1:0]   target_way,
    output logic [DATA_WIDTH-1:0]  data_in,
    output logic                   dirty,
    input  logic                   hit,
    input  logic [WAY_SEL_W-1:0]   hit_way,
    input  logic [DATA_WIDTH-1:0]  data_out,
    input  logic [WAY_SEL_W-1:0]   lru_way,
    input  logic                   victim_dirty,
    input  logic [TAG_WIDTH-1:0]   victim_tag,
    input  logic [DATA_WIDTH-1:0]  victim_data
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count,
    output logic [15:0]            wb_count
`endif
);

    localparam int INDEX_LSB = BYTE_OFFSET;
    localparam int TAG_LSB   = BYTE_OFFSET + INDEX_WIDTH;

    state_t                 r_state;
    state_t                 w_next;

    // Latched request (only the line-address fields are kept)
    logic [INDEX_WIDTH-1:0] r_index;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic                   r_we;
    logic [DATA_WIDTH-1:0]  r_wdata;

    // Miss bookkeeping
    logic [WAY_SEL_W-1:0]   r_victim_way;
    logic [TAG_WIDTH-1:0]   r_victim_tag;
    logic [DATA_WIDTH-1:0]  r_victim_data;
    logic [DATA_WIDTH-1:0]  r_fetch;
    logic [DATA_WIDTH-1:0]  r_rdata;

    logic                   w_accept;
    logic                   w_unused_offset;

    // Byte-offset bits never reach the array or memory: lines are one word
    assign w_unused_offset = ^cpu_addr[BYTE_OFFSET-1:0];

    assign w_accept  = cpu_req && (r_state == ST_IDLE);
    assign index     = r_index;
    assign tag       = r_tag;
    assign cpu_rdata = r_rdata;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_index       <= '0;
            r_tag         <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_victim_way  <= '0;
            r_victim_tag  <= '0;
            r_victim_data <= '0;
            r_fetch       <= '0;
            r_rdata       <= '0;
        end else begin
            r_state <= w_next;

            if (w_accept) begin
                r_index <= cpu_addr[INDEX_LSB +: INDEX_WIDTH];
                r_tag   <= cpu_addr[TAG_LSB +: TAG_WIDTH];
                r_we    <= cpu_we;
                r_wdata <= cpu_wdata;
            end

            if (r_state == ST_LOOKUP) begin
                if (hit) begin
                    if (!r_we) r_rdata <= data_out;
                end else begin
                    // Snapshot the victim now: the fill overwrites it later
                    r_victim_way  <= lru_way;
                    r_victim_tag  <= victim_tag;
                    r_victim_data <= victim_data;
                end
            end

            if ((r_state == ST_ALLOCATE) && mem_ack) r_fetch <= mem_rdata;

            // Write misses also return the fetched (pre-write) word
            if (r_state == ST_FILL) r_rdata <= r_fetch;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        cpu_ready  = 1'b0;
        cpu_resp   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        data_wen   = 1'b0;
        update_lru = 1'b0;
        target_way = '0;
        data_in    = '0;
        dirty      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) w_next = ST_LOOKUP;
            end

            ST_LOOKUP: begin
                if (hit) begin
                    update_lru = 1'b1;
                    target_way = hit_way;
                    if (r_we) begin
                        data_wen = 1'b1;
                        data_in  = r_wdata;
                        dirty    = 1'b1;
                    end
                    w_next = ST_RESPOND;
                end else begin
                    w_next = victim_dirty ? ST_WRITEBACK : ST_ALLOCATE;
                end
            end

            ST_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_victim_tag, r_index, {BYTE_OFFSET{1'b0}}};
                mem_wdata = r_victim_data;
                if (mem_ack) w_next = ST_ALLOCATE;
            end

            ST_ALLOCATE: begin
                mem_req  = 1'b1;
                mem_addr = {r_tag, r_index, {BYTE_OFFSET{1'b0}}};
                if (mem_ack) w_next = ST_FILL;
            end

            ST_FILL: begin
                data_wen   = 1'b1;
                update_lru = 1'b1;
                target_way = r_victim_way;
                data_in    = r_we ? r_wdata : r_fetch;
                dirty      = r_we;
                w_next     = ST_RESPOND;
            end

            ST_RESPOND: begin
                cpu_resp = 1'b1;
                w_next   = ST_IDLE;
            end

            default: w_next = ST_IDLE;
        endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    cache_ctrl_stats #(
        .CNT_W (16)
    ) u_stats (
        .clk          (clk),
        .rst          (rst),
        .i_hit_evt    ((r_state == ST_LOOKUP) && hit),
        .i_miss_evt   ((r_state == ST_LOOKUP) && !hit),
        .i_wb_evt     ((r_state == ST_WRITEBACK) && mem_ack),
        .o_hit_count  (hit_count),
        .o_miss_count (miss_count),
        .o_wb_count   (wb_count)
    );
`endif

endmodule : cache_controller

`default_nettype wire

// File: tb/tb_cache_controller.sv
// ============================================================================
//  Module  : tb_cache_controller
//  Purpose : Self-checking bench for cache_controller. Provides a behavioural
//            4-way true-LRU array, a latency-programmable backing memory and
//            a flat reference memory of CPU-visible values. A vector table
//            drives accesses; expected results go into a queue and are
//            popped when cpu_resp arrives.
//  Config  : CACHE_CTRL_STATS_EN also checks the statistics counters
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cache_controller;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready, cpu_resp;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [5:0]  index;
    logic [7:0]  tag;
    logic        data_wen, update_lru, dirty;
    logic [1:0]  target_way;
    logic [31:0] data_in;
    logic        hit;
    logic [1:0]  hit_way, lru_way;
    logic [31:0] data_out, victim_data;
    logic        victim_dirty;
    logic [7:0]  victim_tag;
`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hit_count, miss_count, wb_count;
`endif

    cache_controller dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_resp(cpu_resp), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .index(index), .tag(tag), .data_wen(data_wen), .update_lru(update_lru),
        .target_way(target_way), .data_in(data_in), .dirty(dirty),
        .hit(hit), .hit_way(hit_way), .data_out(data_out), .lru_way(lru_way),
        .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_data(victim_data)
`ifdef CACHE_CTRL_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Behavioural 4-way array, true LRU by touch timestamp
    // ------------------------------------------------------------------
    logic        a_valid [4][64];
    logic        a_dirty [4][64];
    logic [7:0]  a_tag   [4][64];
    logic [31:0] a_data  [4][64];
    int          a_stamp [4][64];
    int          tick;
    logic        m_found;
    int          m_best;

    always_comb begin
        hit      = 1'b0;
        hit_way  = 2'd0;
        data_out = 32'd0;
        lru_way  = 2'd0;
        m_found  = 1'b0;
        m_best   = 0;
        for (int w = 0; w < 4; w++) begin
            if (a_valid[w][index] && (a_tag[w][index] == tag)) begin
                hit      = 1'b1;
                hit_way  = 2'(w);
                data_out = a_data[w][index];
            end
        end
        for (int w = 0; w < 4; w++) begin
            if (!m_found && !a_valid[w][index]) begin
                lru_way = 2'(w);
                m_found = 1'b1;
            end
        end
        if (!m_found) begin
            m_best = a_stamp[0][index];
            for (int w = 1; w < 4; w++) begin
                if (a_stamp[w][index] < m_best) begin
                    m_best  = a_stamp[w][index];
                    lru_way = 2'(w);
                end
            end
        end
        victim_dirty = a_valid[lru_way][index] & a_dirty[lru_way][index];
        victim_tag   = a_tag[lru_way][index];
        victim_data  = a_data[lru_way][index];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < 4; w++)
                for (int s = 0; s < 64; s++) begin
                    a_valid[w][s] <= 1'b0;
                    a_dirty[w][s] <= 1'b0;
                    a_tag[w][s]   <= 8'd0;
                    a_data[w][s]  <= 32'd0;
                    a_stamp[w][s] <= 0;
                end
            tick <= 1;
        end else begin
            if (data_wen) begin
                a_valid[target_way][index] <= 1'b1;
                a_tag[target_way][index]   <= tag;
                a_data[target_way][index]  <= data_in;
                a_dirty[target_way][index] <= dirty;
            end
            if (update_lru) begin
                a_stamp[target_way][index] <= tick;
                tick <= tick + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Backing memory: acks N cycles after the request is first seen;
    // an abandoned request (reset) is discarded.
    // ------------------------------------------------------------------
    logic [31:0] mem_store [0:16383];
    logic [31:0] ref_mem   [0:16383];
    int          mem_lat = 3;
    int          mem_cnt;
    int          n_fetch, n_wb;
    logic [15:0] last_fetch_addr, last_wb_addr, cap_addr;
    logic [31:0] last_wb_data, cap_wdata;
    logic        cap_we;

    always @(negedge clk) begin
        if (rst) begin
            mem_ack = 1'b0;
            mem_cnt = 0;
        end else begin
            if (mem_ack) begin
                mem_ack = 1'b0;
                mem_cnt = 0;
            end
            if (mem_req) begin
                if (mem_cnt == 0) begin
                    cap_addr  = mem_addr;
                    cap_we    = mem_we;
                    cap_wdata = mem_wdata;
                end
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    check("mem_hold_stable", {15'd0, mem_we, mem_addr} ^ {mem_wdata ^ cap_wdata},
                          {15'd0, cap_we, cap_addr});
                    if (mem_we) begin
                        mem_store[mem_addr[15:2]] = mem_wdata;
                        n_wb++;
                        last_wb_addr = mem_addr;
                        last_wb_data = mem_wdata;
                    end else begin
                        mem_rdata = mem_store[mem_addr[15:2]];
                        n_fetch++;
                        last_fetch_addr = mem_addr;
                    end
                    mem_ack = 1'b1;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Vector table and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          kind;      // 0 hit, 1 clean miss, 2 dirty miss
        int          n;         // memory ack latency
        logic [15:0] wb_addr;   // expected writeback line (dirty miss)
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    function automatic vec_t mk(input logic we, input logic [15:0] a, input logic [31:0] d,
                                input int kind, input int n, input logic [15:0] wb);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.kind = kind; v.n = n; v.wb_addr = wb;
        return v;
    endfunction

    task automatic do_access(input vec_t v);
        exp_t        e;
        exp_t        got;
        int          lat;
        bit          done;
        bit          wr_seen;
        logic [31:0] wr_data;
        logic        wr_dirty;
        logic [31:0] exp_wb_data;
        int          guard;

        guard = 0;
        while (!cpu_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_req", {31'd0, cpu_ready}, 32'd1);

        mem_lat     = v.n;
        n_fetch     = 0;
        n_wb        = 0;
        wr_seen     = 0;
        wr_data     = 32'd0;
        wr_dirty    = 1'b0;
        exp_wb_data = ref_mem[v.wb_addr[15:2]];

        e.rdata = ref_mem[v.addr[15:2]];
        e.lat   = (v.kind == 0) ? 2 : (v.kind == 1) ? 3 + v.n : 3 + 2 * v.n;
        exp_q.push_back(e);
        if (v.we) ref_mem[v.addr[15:2]] = v.wdata;

        cpu_req   = 1'b1;
        cpu_we    = v.we;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        @(posedge clk);
        #1 cpu_req = 1'b0;

        lat  = 0;
        done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            lat++;
            if (data_wen) begin
                wr_seen  = 1;
                wr_data  = data_in;
                wr_dirty = dirty;
            end
            if (cpu_resp) done = 1;
        end
        got = exp_q.pop_front();
        check("resp_seen", {31'd0, done}, 32'd1);
        check("resp_latency", lat, got.lat);
        if (!v.we) check("cpu_rdata", cpu_rdata, got.rdata);
        check("fetch_count", n_fetch, (v.kind == 0) ? 0 : 1);
        check("wb_count_mem", n_wb, (v.kind == 2) ? 1 : 0);
        if (v.kind != 0) check("fetch_addr", {16'd0, last_fetch_addr}, {16'd0, v.addr[15:2], 2'b00});
        if (v.kind == 2) begin
            check("wb_addr", {16'd0, last_wb_addr}, {16'd0, v.wb_addr});
            check("wb_data", last_wb_data, exp_wb_data);
        end
        check("array_write", {31'd0, wr_seen}, {31'd0, (v.we || v.kind != 0)});
        if (v.we || v.kind != 0) begin
            check("array_data_in", wr_data, v.we ? v.wdata : got.rdata);
            check("array_dirty", {31'd0, wr_dirty}, {31'd0, v.we});
        end
        @(negedge clk);
        check("ready_after_resp", {31'd0, cpu_ready}, 32'd1);
    endtask

    vec_t vecs [16];
    bit   got_alloc;

    initial begin
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'd0;
        cpu_wdata = 32'd0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        n_fetch   = 0;
        n_wb      = 0;
        for (int i = 0; i < 16384; i++) begin
            mem_store[i] = 32'hA500_0000 ^ (i * 32'h0001_0003);
            ref_mem[i]   = mem_store[i];
        end
        mem_store[16'h0104 >> 2] = 32'hDEAD_BEEF;
        ref_mem[16'h0104 >> 2]   = 32'hDEAD_BEEF;

        // Set 1 (0x?04) exercises LRU and dirty eviction; set 2 the write miss
        vecs[0]  = mk(0, 16'h0104, 32'h0,         1, 3, 16'h0);
        vecs[1]  = mk(0, 16'h0104, 32'h0,         0, 3, 16'h0);
        vecs[2]  = mk(1, 16'h0104, 32'h1234_5678, 0, 3, 16'h0);
        vecs[3]  = mk(0, 16'h0204, 32'h0,         1, 3, 16'h0);
        vecs[4]  = mk(0, 16'h0304, 32'h0,         1, 3, 16'h0);
        vecs[5]  = mk(0, 16'h0404, 32'h0,         1, 3, 16'h0);
        vecs[6]  = mk(0, 16'h0504, 32'h0,         2, 3, 16'h0104);
        vecs[7]  = mk(1, 16'h0808, 32'hCAFE_F00D, 1, 1, 16'h0);
        vecs[8]  = mk(0, 16'h0808, 32'h0,         0, 3, 16'h0);
        vecs[9]  = mk(0, 16'h0104, 32'h0,         1, 3, 16'h0);
        vecs[10] = mk(0, 16'h0204, 32'h0,         1, 2, 16'h0);
        vecs[11] = mk(1, 16'h0104, 32'hAAAA_5555, 0, 3, 16'h0);
        vecs[12] = mk(0, 16'h0404, 32'h0,         0, 3, 16'h0);
        vecs[13] = mk(0, 16'h0304, 32'h0,         1, 3, 16'h0);
        vecs[14] = mk(0, 16'h0504, 32'h0,         1, 3, 16'h0);
        vecs[15] = mk(0, 16'h0604, 32'h0,         2, 2, 16'h0104);

        rst = 1'b0;
        #1 rst = 1'b1;
        #3;
        check("rst_cpu_ready",  {31'd0, cpu_ready},  32'd1);
        check("rst_cpu_resp",   {31'd0, cpu_resp},   32'd0);
        check("rst_cpu_rdata",  cpu_rdata,           32'd0);
        check("rst_mem_req",    {31'd0, mem_req},    32'd0);
        check("rst_mem_addr",   {16'd0, mem_addr},   32'd0);
        check("rst_index_tag",  {18'd0, index, tag}, 32'd0);
        check("rst_array_ctl",  {28'd0, data_wen, update_lru, target_way}, 32'd0);
        check("rst_data_in",    data_in,             32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            do_access(vecs[i]);
`ifdef CACHE_CTRL_STATS_EN
            if (i == 1) begin
                check("stats_hit_early",  {16'd0, hit_count},  32'd1);
                check("stats_miss_early", {16'd0, miss_count}, 32'd1);
                check("stats_wb_early",   {16'd0, wb_count},   32'd0);
            end
`endif
        end
`ifdef CACHE_CTRL_STATS_EN
        check("stats_hit",  {16'd0, hit_count},  32'd5);
        check("stats_miss", {16'd0, miss_count}, 32'd11);
        check("stats_wb",   {16'd0, wb_count},   32'd2);
`endif

        // Reset in the middle of a line fetch
        mem_lat   = 3;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0C10;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        got_alloc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_req && !mem_we) begin
                got_alloc = 1;
                break;
            end
        end
        check("reach_allocate", {31'd0, got_alloc}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_mem_req",   {31'd0, mem_req},   32'd0);
        check("midrst_cpu_ready", {31'd0, cpu_ready}, 32'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, cpu_ready}, 32'd1);
        do_access(mk(0, 16'h0C10, 32'h0, 1, 3, 16'h0));
`ifdef CACHE_CTRL_STATS_EN
        check("stats_after_rst_miss", {16'd0, miss_count}, 32'd1);
        check("stats_after_rst_hit",  {16'd0, hit_count},  32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_cache_controller

`default_nettype wire
